// File: rtl/mig_tt_pkg.sv
// Shared types and helpers for the MIG truth-table sweeper and NPN mapping logic.
package mig_tt_pkg;

  localparam int N_IN   = 4;
  localparam int TT_W   = 16;
  localparam int PERM_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    APPLY,
    WAIT,
    CAPTURE,
    FINISH
  } state_t;

  // Sweep configuration captured on an accepted start.
  typedef struct packed {
    logic [N_IN-1:0][PERM_W-1:0] perm;
    logic [N_IN-1:0]             neg;
    logic                        out_neg;
    logic [TT_W-1:0]             expect_tt;
  } cfg_t;

  // Four 2-bit fields drawn from four values are distinct iff every value appears.
  function automatic logic perm_valid(input logic [7:0] p);
    logic [N_IN-1:0] seen;
    seen = '0;
    for (int i = 0; i < N_IN; i++) seen[p[2*i +: 2]] = 1'b1;
    return &seen;
  endfunction

endpackage

// File: rtl/npn_input_map.sv
// Combinational NPN input map: x_next[i] = idx[perm[i]] ^ neg[i].
module npn_input_map
  import mig_tt_pkg::*;
(
  input  logic [N_IN-1:0]             idx,
  input  logic [N_IN-1:0][PERM_W-1:0] perm,
  input  logic [N_IN-1:0]             neg,
  output logic [N_IN-1:0]             x_next
);

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign x_next[i] = idx[perm[i]] ^ neg[i];
  end

endmodule

// File: rtl/mig_tt_sweeper.sv
// Walks a 4-input network through all 16 minterms (with optional NPN transform),
// builds its truth table and compares it against an expected table.
module mig_tt_sweeper
  import mig_tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_IN*PERM_W-1:0]      in_perm,
  input  logic [N_IN-1:0]             in_neg,
  input  logic                        out_neg,
  input  logic [TT_W-1:0]             expect_tt,
  output logic [N_IN-1:0]             x,
  input  logic                        y,
  output logic                        busy,
  output logic                        done,
  output logic [TT_W-1:0]             tt,
  output logic                        match,
  output logic                        err_perm
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t          state, state_d;
  cfg_t            cfg;
  logic [3:0]      idx, idx_d;
  logic [3:0]      cnt;
  logic [N_IN-1:0] x_next;
  logic            accept;

  assign accept = (state == IDLE) && start && !abort;

  // Mapping is fed the index about to be applied so x can be loaded on the APPLY entry edge.
  npn_input_map u_map (
    .idx    (idx_d),
    .perm   (cfg.perm),
    .neg    (cfg.neg),
    .x_next (x_next)
  );

  // Next-state and next-index logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE:    if (start && !abort) state_d = CHECK;
      CHECK: begin
        idx_d   = '0;
        state_d = perm_valid(cfg.perm) ? APPLY : FINISH;
      end
      APPLY:   state_d = (SETTLE > 0) ? WAIT : CAPTURE;
      WAIT:    if (cnt == SETTLE_LAST) state_d = CAPTURE;
      CAPTURE: begin
        if (idx == 4'hF) state_d = FINISH;
        else begin
          idx_d   = idx + 4'd1;
          state_d = APPLY;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state != IDLE)) state_d = IDLE;
  end

  // Control state, sweep index, settle counter and latched configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      cfg   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
      if (accept) cfg <= {in_perm, in_neg, out_neg, expect_tt};
    end
  end

  // Registered outputs: network drive, handshake and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      match    <= 1'b0;
      err_perm <= 1'b0;
    end else begin
      // x moves only on the edge entering APPLY, so the network sees one clean change per index.
      if (state_d == APPLY) x <= x_next;
      busy <= (state_d == APPLY) || (state_d == WAIT) ||
              (state_d == CAPTURE) || (state_d == FINISH);
      done <= (state == FINISH) && !abort;
      if (accept) begin
        tt       <= '0;
        match    <= 1'b0;
        err_perm <= 1'b0;
      end else begin
        if ((state == CAPTURE) && !abort) tt[idx] <= y ^ cfg.out_neg;
        if ((state == CHECK) && !abort && !perm_valid(cfg.perm)) err_perm <= 1'b1;
        if ((state == FINISH) && !abort) match <= (tt == cfg.expect_tt) && !err_perm;
      end
    end
  end

endmodule
